input_debouncer: RTL and testbench

- Conditions one raw asynchronous input (push-button or switch) before it drives the basic-gate datapath, e.g. the NAND-built inverter stage.
- Synchronises the input, rejects bounce with a stability counter, and emits a clean level plus single-cycle edge pulses.
- Sits directly upstream of the combinational gate blocks on the FPGA board top level.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/input_debouncer_sync_2ff.sv | 24 ++
 rtl/input_debouncer.sv | 138 +++++++++++++
 tb/tb_input_debouncer.sv | 137 +++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the input debouncer.
package debounce_pkg;

    localparam int DEF_STABLE_CYCLES = 50000;
    localparam int DEF_CNT_WIDTH     = 16;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'b00,
        CHECK_HIGH = 2'b01,
        IDLE_HIGH  = 2'b10,
        CHECK_LOW  = 2'b11
    } state_t;

    function automatic logic is_check(input state_t s);
        return (s == CHECK_HIGH) || (s == CHECK_LOW);
    endfunction

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw pin into a clean level plus single-cycle rise/fall pulses.
// Build option DEBOUNCE_INVERT_EN inverts din_raw ahead of the synchroniser (active-low buttons).
//
// state      | meaning
// IDLE_LOW   | dout = 0, input agrees with dout
// CHECK_HIGH | dout = 0, synchronised input high, counting stable samples
// IDLE_HIGH  | dout = 1, input agrees with dout
// CHECK_LOW  | dout = 1, synchronised input low, counting stable samples
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_raw,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    if ((STABLE_CYCLES < 2) || (STABLE_CYCLES >= (2 ** CNT_WIDTH))) begin : g_param_err
        $error("input_debouncer: STABLE_CYCLES must be in 2 .. 2**CNT_WIDTH-1");
    end

    localparam logic [CNT_WIDTH-1:0] C_TERM = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic w_din;
    logic w_s2;

`ifdef DEBOUNCE_INVERT_EN
    assign w_din = ~din_raw;
`else
    assign w_din = din_raw;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (w_din),
        .q     (w_s2)
    );

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_dout;
    logic                 w_dout_nxt;
    logic                 r_rise;
    logic                 w_rise_nxt;
    logic                 r_fall;
    logic                 w_fall_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;

        unique case (r_state)
            IDLE_LOW: begin
                if (w_s2) begin
                    w_state_nxt = CHECK_HIGH;
                    w_cnt_nxt   = CNT_WIDTH'(1);
                end
            end
            CHECK_HIGH: begin
                if (!w_s2) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TERM) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_dout_nxt  = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            IDLE_HIGH: begin
                if (!w_s2) begin
                    w_state_nxt = CHECK_LOW;
                    w_cnt_nxt   = CNT_WIDTH'(1);
                end
            end
            CHECK_LOW: begin
                if (w_s2) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TERM) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_dout_nxt  = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase

        // busy is registered alongside the state it describes
        w_busy_nxt = is_check(w_state_nxt);
    end

    assign dout       = r_dout;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign busy       = r_busy;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with STABLE_CYCLES = 4, CNT_WIDTH = 4.
// Stimulus is expressed as logical button level; DEBOUNCE_INVERT_EN flips the pin polarity.
module tb_input_debouncer;

`ifdef DEBOUNCE_INVERT_EN
    localparam logic C_INV = 1'b1;
`else
    localparam logic C_INV = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic din_raw;
    logic dout;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    input_debouncer #(
        .STABLE_CYCLES (4),
        .CNT_WIDTH     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_raw    (din_raw),
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic lvl);
        din_raw = lvl ^ C_INV;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_dout, input logic e_rise,
                           input logic e_fall, input logic e_busy);
        chk({tag, "_dout"}, 32'(dout),       32'(e_dout));
        chk({tag, "_rise"}, 32'(rise_pulse), 32'(e_rise));
        chk({tag, "_fall"}, 32'(fall_pulse), 32'(e_fall));
        chk({tag, "_busy"}, 32'(busy),       32'(e_busy));
    endtask

    // Clean step to lvl from the opposite settled level; input changes just after edge 0.
    task automatic clean_step(input logic lvl, input string tag);
        drive(lvl);
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk_all($sformatf("%s_c%0d", tag, n),
                    (n >= 6) ? lvl : ~lvl,
                    lvl && (n == 6),
                    !lvl && (n == 6),
                    (n >= 3) && (n <= 5));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0);
        repeat (3) tick();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int n = 1; n <= 20; n++) begin
            tick();
            chk_all($sformatf("idle_c%0d", n), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        clean_step(1'b1, "rise");
        repeat (3) tick();
        clean_step(1'b0, "fall");
        repeat (3) tick();

        // bounce: high 3 cycles, low 1 cycle, then steady high from cycle 4
        for (int n = 0; n <= 13; n++) begin
            if (n == 0) drive(1'b1);
            if (n == 3) drive(1'b0);
            if (n == 4) drive(1'b1);
            tick();
            chk_all($sformatf("bounce_c%0d", n + 1),
                    (n + 1) >= 10,
                    (n + 1) == 10,
                    1'b0,
                    ((n + 1) >= 3 && (n + 1) <= 5) || ((n + 1) >= 7 && (n + 1) <= 9));
        end
        clean_step(1'b0, "bfall");
        repeat (3) tick();

        // single-cycle spikes every 3 cycles never qualify
        for (int n = 0; n <= 33; n++) begin
            drive((n % 3 == 0) && (n < 30));
            tick();
            chk_all($sformatf("spike_c%0d", n + 1), 1'b0, 1'b0, 1'b0,
                    ((n + 1) % 3 == 0) && ((n + 1) >= 3) && ((n + 1) <= 30));
        end
        repeat (3) tick();

        // asynchronous reset in CHECK_HIGH with cnt = 2
        drive(1'b1);
        repeat (4) tick();
        chk_all("prerst", 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("asyncrst", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk_all("inrst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk_all($sformatf("postrst_c%0d", n), n >= 6, n == 6, 1'b0, (n >= 3) && (n <= 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
